// File: rtl/comb_path_seq_pkg.sv
// comb_path_seq_pkg: shared types and helpers for the comb_path sequencer.
// Holds the FSM state encoding and the path inversion-parity function.
package comb_path_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CHECK,
        DONE
    } seq_state_t;

    // A DEPTH-stage path contains DEPTH/2 inverters.
    function automatic logic inv_parity(input int unsigned depth);
        return 1'((depth / 2) % 2);
    endfunction

endpackage

// File: rtl/comb_path_sequencer.sv
// comb_path_sequencer: launch/capture controller for an external comb_path.
// Toggles the launch flop, captures after a programmed wait, checks polarity.
module comb_path_sequencer
    import comb_path_seq_pkg::*;
#(
    parameter int DEPTH  = 10,
    parameter int WAIT_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_n_iter,
    input  logic [WAIT_W-1:0] cfg_wait,
    output logic              path_launch,
    input  logic              path_capture,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail
);

    localparam logic              INV_PAR = inv_parity(DEPTH);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
    localparam logic [WAIT_W-1:0] W_ONE   = WAIT_W'(1);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic              r_launch;
    logic              r_cap;
    logic              r_stop_req;
    logic [WAIT_W-1:0] r_wcnt;
    logic [WAIT_W-1:0] r_eff_wait;
    logic [CNT_W-1:0]  r_n_iter;
    logic [CNT_W-1:0]  r_iter;
    logic [CNT_W-1:0]  r_pass;
    logic [CNT_W-1:0]  r_fail;
    logic [CNT_W-1:0]  r_first_fail;

    logic              w_cap_ok;
    logic              w_last;
    logic [WAIT_W-1:0] w_eff_wait;
    logic [CNT_W:0]    w_iter_nx;

    assign w_eff_wait = (cfg_wait == '0) ? W_ONE : cfg_wait;
    assign w_cap_ok   = (r_cap == (r_launch ^ INV_PAR));
    // Extra bit keeps a saturated iter from aliasing onto n_iter.
    assign w_iter_nx  = {1'b0, r_iter} + (CNT_W + 1)'(1);
    assign w_last     = r_stop_req ||
                        ((r_n_iter != '0) &&
                         (w_iter_nx == {1'b0, r_n_iter}));

    assign path_launch = r_launch;
    assign pass_cnt    = r_pass;
    assign fail_cnt    = r_fail;
    assign first_fail  = r_first_fail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        done     = 1'b0;
        mismatch = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = LAUNCH;
            end
            LAUNCH: w_next = WAIT;
            WAIT: begin
                if (r_wcnt == '0) w_next = CHECK;
            end
            CHECK: begin
                mismatch = !w_cap_ok;
                w_next   = w_last ? DONE : LAUNCH;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_launch     <= 1'b0;
            r_cap        <= 1'b0;
            r_stop_req   <= 1'b0;
            r_wcnt       <= '0;
            r_eff_wait   <= '0;
            r_n_iter     <= '0;
            r_iter       <= '0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_first_fail <= '0;
        end else begin
            if (r_state != IDLE && stop) r_stop_req <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n_iter     <= cfg_n_iter;
                        r_eff_wait   <= w_eff_wait;
                        r_iter       <= '0;
                        r_pass       <= '0;
                        r_fail       <= '0;
                        r_first_fail <= '0;
                        r_stop_req   <= 1'b0;
                    end
                end
                LAUNCH: begin
                    r_launch <= ~r_launch;
                    r_wcnt   <= r_eff_wait - W_ONE;
                end
                WAIT: begin
                    if (r_wcnt != '0) r_wcnt <= r_wcnt - W_ONE;
                    else              r_cap  <= path_capture;
                end
                CHECK: begin
                    if (w_cap_ok) begin
                        if (r_pass != '1) r_pass <= r_pass + C_ONE;
                    end else begin
                        if (r_fail == '0) r_first_fail <= r_iter;
                        if (r_fail != '1) r_fail <= r_fail + C_ONE;
                    end
                    if (r_iter != '1) r_iter <= r_iter + C_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comb_path_sequencer.sv
// tb_comb_path_sequencer: directed and randomized checks of the sequencer
// against a timeline-based reference model of launch/capture runs.
module tb_comb_path_sequencer;

    typedef struct {
        bit run;
        bit in_done;
        bit in_check;
        bit cap_bad;
        bit stop_req;
        bit launch;
        int t;
        int ew;
        int n;
        int iter;
        int pass;
        int fail;
        int ff;
        int maxv;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] n_iter = '0;
    logic [3:0]  cfg_wait = '0;
    logic        path_launch;
    logic        path_capture;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [15:0] first_fail;

    logic        s_start = 1'b0;
    logic        s_stop = 1'b0;
    logic [2:0]  s_n_iter = '0;
    logic [3:0]  s_wait = '0;
    logic        s_launch;
    logic        s_capture;
    logic        s_busy;
    logic        s_done;
    logic        s_mismatch;
    logic [2:0]  s_pass;
    logic [2:0]  s_fail;
    logic [2:0]  s_ff;

    bit corrupt = 1'b0;
    bit fault   = 1'b0;
    bit chk_en  = 1'b0;
    int n_pass  = 0;
    int n_total = 0;
    int cyc;
    mdl_t m0;
    mdl_t m1;

    // DEPTH=10 path: five inverters, so the output is the inverted launch.
    assign path_capture = path_launch ^ 1'b1 ^ corrupt ^ fault;
    assign s_capture    = s_launch ^ 1'b1;

    always #5 clk = ~clk;

    comb_path_sequencer #(.DEPTH(10), .WAIT_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_n_iter(n_iter), .cfg_wait(cfg_wait),
        .path_launch(path_launch), .path_capture(path_capture),
        .busy(busy), .done(done), .mismatch(mismatch),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail)
    );

    comb_path_sequencer #(.DEPTH(10), .WAIT_W(4), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .stop(s_stop),
        .cfg_n_iter(s_n_iter), .cfg_wait(s_wait),
        .path_launch(s_launch), .path_capture(s_capture),
        .busy(s_busy), .done(s_done), .mismatch(s_mismatch),
        .pass_cnt(s_pass), .fail_cnt(s_fail), .first_fail(s_ff)
    );

    function automatic mdl_t mreset(int maxv);
        mdl_t r;
        r = '{default: 0};
        r.maxv = maxv;
        return r;
    endfunction

    // One clock edge of a run: edge t (t>=1 after the start edge) lies at
    // phase (t-1) mod (eff_wait+2) of iteration (t-1) div (eff_wait+2).
    function automatic mdl_t step(mdl_t m, bit st, bit sp, int n, int w,
                                  bit bad);
        mdl_t r;
        int ph;
        r = m;
        r.in_check = 0;
        if (!m.run) begin
            if (st) begin
                r.run = 1; r.t = 0; r.ew = (w == 0) ? 1 : w; r.n = n;
                r.iter = 0; r.pass = 0; r.fail = 0; r.ff = 0;
                r.stop_req = 0; r.in_done = 0;
            end
            return r;
        end
        if (m.in_done) begin
            r.run = 0; r.in_done = 0;
            return r;
        end
        if (sp) r.stop_req = 1;
        r.t = m.t + 1;
        ph = (r.t - 1) % (m.ew + 2);
        if (ph == 0) r.launch = !m.launch;
        if (ph == m.ew) begin
            r.cap_bad = bad;
            r.in_check = 1;
        end
        if (ph == m.ew + 1) begin
            if (!m.cap_bad) begin
                r.pass = (m.pass < m.maxv) ? m.pass + 1 : m.maxv;
            end else begin
                if (m.fail == 0) r.ff = m.iter;
                r.fail = (m.fail < m.maxv) ? m.fail + 1 : m.maxv;
            end
            if (m.stop_req || (m.n != 0 && m.iter + 1 == m.n)) r.in_done = 1;
            r.iter = (m.iter < m.maxv) ? m.iter + 1 : m.maxv;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 = mreset(65535);
            m1 = mreset(7);
        end else begin
            m0 = step(m0, start, stop, int'(n_iter), int'(cfg_wait),
                      corrupt ^ fault);
            m1 = step(m1, s_start, s_stop, int'(s_n_iter), int'(s_wait),
                      1'b0);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                      $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("launch",   int'(path_launch), int'(m0.launch));
            chk("busy",     int'(busy),        int'(m0.run));
            chk("done",     int'(done),        int'(m0.in_done));
            chk("mismatch", int'(mismatch),    int'(m0.in_check && m0.cap_bad));
            chk("pass",     int'(pass_cnt),    m0.pass);
            chk("fail",     int'(fail_cnt),    m0.fail);
            chk("ffail",    int'(first_fail),  m0.ff);
            chk("s_launch", int'(s_launch),    int'(m1.launch));
            chk("s_busy",   int'(s_busy),      int'(m1.run));
            chk("s_done",   int'(s_done),      int'(m1.in_done));
            chk("s_mism",   int'(s_mismatch),  int'(m1.in_check && m1.cap_bad));
            chk("s_pass",   int'(s_pass),      m1.pass);
            chk("s_fail",   int'(s_fail),      m1.fail);
            chk("s_ffail",  int'(s_ff),        m1.ff);
        end
    end

    // Negedge k of the wait loop follows edge k-1 after the start edge, so
    // the cycle number (start cycle = 1) of that negedge is k+1.
    task automatic run(input bit sel, input int n, input int w,
                       input int stop_at, output int c);
        @(posedge clk); #2;
        if (sel) begin
            s_start = 1'b1; s_n_iter = 3'(n); s_wait = 4'(w);
        end else begin
            start = 1'b1; n_iter = 16'(n); cfg_wait = 4'(w);
        end
        @(posedge clk); #2;
        start = 1'b0;
        s_start = 1'b0;
        c = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == stop_at) begin
                if (sel) s_stop = 1'b1;
                else     stop = 1'b1;
            end else begin
                stop = 1'b0;
                s_stop = 1'b0;
            end
            if (sel ? s_done : done) begin
                c = k + 1;
                break;
            end
        end
        stop = 1'b0;
        s_stop = 1'b0;
        if (c == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        m0 = mreset(65535);
        m1 = mreset(7);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pass", int'(pass_cnt), 0);
        chk("rst_launch", int'(path_launch), 0);

        run(1'b0, 4, 2, 0, cyc);
        chk("t1_cycles", cyc, 18);
        chk("t1_pass", int'(pass_cnt), 4);
        chk("t1_fail", int'(fail_cnt), 0);

        fault = 1'b1;
        run(1'b0, 4, 2, 0, cyc);
        chk("t2_fail", int'(fail_cnt), 4);
        chk("t2_pass", int'(pass_cnt), 0);
        chk("t2_ffail", int'(first_fail), 0);
        fault = 1'b0;

        run(1'b0, 2, 0, 0, cyc);
        chk("t3_cycles", cyc, 8);
        chk("t3_pass", int'(pass_cnt), 2);

        run(1'b0, 0, 2, 11, cyc);
        chk("t4_cycles", cyc, 14);
        chk("t4_pass", int'(pass_cnt), 3);
        @(negedge clk);
        chk("t4_idle", int'(busy), 0);

        run(1'b1, 0, 1, 29, cyc);
        chk("t5_cycles", cyc, 32);
        chk("t5_pass", int'(s_pass), 7);
        chk("t5_fail", int'(s_fail), 0);

        @(posedge clk); #2;
        start = 1'b1; n_iter = 16'd4; cfg_wait = 4'd2;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_launch", int'(path_launch), 0);
        chk("t6_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run(1'b0, 4, 2, 0, cyc);
        chk("t6_cycles", cyc, 18);
        chk("t6_pass", int'(pass_cnt), 4);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            start    = ($urandom % 8) == 0;
            stop     = ($urandom % 12) == 0;
            n_iter   = 16'($urandom % 6);
            cfg_wait = 4'($urandom % 5);
            corrupt  = ($urandom % 4) == 0;
        end
        @(posedge clk); #2;
        start = 1'b0; corrupt = 1'b0; stop = 1'b1;
        for (int i = 0; i < 40 && busy; i++) @(posedge clk);
        #2 stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end_idle", int'(busy), 0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
